// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control bundle between the RCPU sequencer and the datapath.
// The master side (the sequencer) reads the instruction register and memory
// handshake and drives the mux selects and write enables; the slave side is
// the datapath. REGS/AW must match the parameters of the attached sequencer.
interface cpu_sequencer_if #(
  parameter int REGS = 4,
  parameter int AW   = 3
);
  logic [15:0]     opcode;
  logic            memReady;
  logic            memReq;
  logic [1:0]      memAddr;
  logic            enPC;
  logic            saveOpcode;
  logic            saveMem;
  logic            saveAddr;
  logic [3:0]      aluFunc;
  logic [AW-1:0]   aluA;
  logic [AW-1:0]   aluB;
  logic [REGS-1:0] regWrite;
  logic            halted;

  modport master (
    input  opcode, memReady,
    output memReq, memAddr, enPC, saveOpcode, saveMem, saveAddr,
    output aluFunc, aluA, aluB, regWrite, halted
  );

  modport slave (
    output opcode, memReady,
    input  memReq, memAddr, enPC, saveOpcode, saveMem, saveAddr,
    input  aluFunc, aluA, aluB, regWrite, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the RCPU datapath.
// Flow: FETCH -> DECODE -> [RIMM | RADDR -> RDIR] -> EXEC -> FETCH, with a
// terminal HALT for the halt instruction, invalid opcodes and bad operands.
// Memory states hold memReq/memAddr until memReady; write enables only fire
// in the cycle the memory completes.
// Optional feature: define CPU_SEQ_DIRECT_EN to build the direct operand mode
// (s1 = 101 reads its operand through an address fetched from the stream).
// Outputs are decoded combinationally from state, opcode and memReady so the
// datapath sees the enables in the same cycle the memory completes; reset
// forces them all low.
module cpu_sequencer #(
  parameter int REGS = 4,
  parameter int AW   = 3
) (
  input logic              clk,
  input logic              rst,
  cpu_sequencer_if.master  bus
);

  // Mux select encodings shared with the datapath.
  localparam logic [AW-1:0] SEL_A_MEM   = AW'(3'd4);
  localparam logic [AW-1:0] SEL_A_PC    = AW'(3'd5);
  localparam logic [AW-1:0] SEL_B_ONE   = AW'(3'd4);
  localparam logic [AW-1:0] SEL_B_IMM   = AW'(3'd5);
  localparam logic [1:0]    ADDR_PC     = 2'd0;
  localparam logic [1:0]    ADDR_AREG   = 2'd1;
  localparam logic [3:0]    FUNC_ADD    = 4'd0;

`ifdef CPU_SEQ_DIRECT_EN
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_RIMM   = 3'd2,
    ST_RADDR  = 3'd3,
    ST_RDIR   = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALT   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_RIMM   = 3'd2,
    ST_EXEC   = 3'd5,
    ST_HALT   = 3'd6
  } state_t;
`endif

  typedef enum logic [1:0] {
    CL_A   = 2'd0,
    CL_HLT = 2'd1,
    CL_I   = 2'd2,
    CL_BAD = 2'd3
  } iclass_t;

  // Instruction class from the top opcode bits.
  function automatic iclass_t op_class(input logic [15:0] op);
    iclass_t c;
    if (op[15:12] == 4'b0000) begin
      c = CL_A;
    end else if (op[15:12] == 4'b0001) begin
      c = CL_HLT;
    end else if (op[15:14] == 2'b01) begin
      c = CL_I;
    end else begin
      c = CL_BAD;
    end
    return c;
  endfunction

  // One-hot register enable; codes beyond the register file give no bit.
  function automatic logic [REGS-1:0] reg_onehot(input logic [1:0] idx);
    logic [REGS-1:0] r;
    for (int i = 0; i < REGS; i++) begin
      r[i] = (int'(idx) == i);
    end
    return r;
  endfunction

  // Zero-extend a 2-bit register code onto a select bus.
  function automatic logic [AW-1:0] reg_sel(input logic [1:0] idx);
    return {{(AW-2){1'b0}}, idx};
  endfunction

  state_t          state_r;
  iclass_t         cls_s;
  logic [2:0]      s1_s;
  logic            src_a_bad_s;
  logic            src_b_bad_s;
  logic            exec_fault_s;
  state_t          decode_next_s;

  logic            mem_req_s;
  logic [1:0]      mem_addr_s;
  logic            en_pc_s;
  logic            save_opcode_s;
  logic            save_mem_s;
  logic            save_addr_s;
  logic [3:0]      alu_func_s;
  logic [AW-1:0]   alu_a_s;
  logic [AW-1:0]   alu_b_s;
  logic [REGS-1:0] reg_write_s;
  logic            halted_s;

  // Opcode bit 2 carries no control meaning.
  logic            unused_s;
  assign unused_s = bus.opcode[2];

  assign cls_s = op_class(bus.opcode);
  assign s1_s  = bus.opcode[11:9];

  // Operand checks: register source codes outside the file halt the CPU.
  always_comb begin
    src_a_bad_s  = (!s1_s[2]) && (int'(s1_s[1:0]) >= REGS);
    if (cls_s == CL_A) begin
      src_b_bad_s = (int'(bus.opcode[4:3]) >= REGS);
    end else begin
      src_b_bad_s = 1'b0;
    end
    exec_fault_s = src_a_bad_s || src_b_bad_s ||
                   (cls_s == CL_HLT) || (cls_s == CL_BAD);
  end

  // Decode routing from the registered opcode.
  always_comb begin
    decode_next_s = ST_HALT;
    case (cls_s)
      CL_A, CL_I: begin
        if (!s1_s[2]) begin
          decode_next_s = ST_EXEC;
        end else if (s1_s == 3'b100) begin
          decode_next_s = ST_RIMM;
`ifdef CPU_SEQ_DIRECT_EN
        end else if (s1_s == 3'b101) begin
          decode_next_s = ST_RADDR;
`endif
        end else begin
          decode_next_s = ST_HALT;
        end
      end
      default: decode_next_s = ST_HALT;
    endcase
  end

  // State register: memory states advance only on memReady, HALT is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH:  state_r <= bus.memReady ? ST_DECODE : ST_FETCH;
        ST_DECODE: state_r <= decode_next_s;
        ST_RIMM:   state_r <= bus.memReady ? ST_EXEC : ST_RIMM;
`ifdef CPU_SEQ_DIRECT_EN
        ST_RADDR:  state_r <= bus.memReady ? ST_RDIR : ST_RADDR;
        ST_RDIR:   state_r <= bus.memReady ? ST_EXEC : ST_RDIR;
`endif
        ST_EXEC:   state_r <= exec_fault_s ? ST_HALT : ST_FETCH;
        ST_HALT:   state_r <= ST_HALT;
        default:   state_r <= ST_HALT;
      endcase
    end
  end

  // Control decode; every enable defaults low so stalls and reset are inert.
  always_comb begin
    mem_req_s     = 1'b0;
    mem_addr_s    = ADDR_PC;
    en_pc_s       = 1'b0;
    save_opcode_s = 1'b0;
    save_mem_s    = 1'b0;
    save_addr_s   = 1'b0;
    alu_func_s    = FUNC_ADD;
    alu_a_s       = '0;
    alu_b_s       = '0;
    reg_write_s   = '0;
    halted_s      = 1'b0;
    if (rst) begin
      halted_s = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          mem_req_s  = 1'b1;
          mem_addr_s = ADDR_PC;
          if (bus.memReady) begin
            save_opcode_s = 1'b1;
            en_pc_s       = 1'b1;
            alu_a_s       = SEL_A_PC;
            alu_b_s       = SEL_B_ONE;
            alu_func_s    = FUNC_ADD;
          end else begin
            save_opcode_s = 1'b0;
          end
        end
        ST_DECODE: begin
          mem_req_s = 1'b0;
        end
        ST_RIMM: begin
          mem_req_s  = 1'b1;
          mem_addr_s = ADDR_PC;
          if (bus.memReady) begin
            save_mem_s = 1'b1;
            en_pc_s    = 1'b1;
            alu_a_s    = SEL_A_PC;
            alu_b_s    = SEL_B_ONE;
            alu_func_s = FUNC_ADD;
          end else begin
            save_mem_s = 1'b0;
          end
        end
`ifdef CPU_SEQ_DIRECT_EN
        ST_RADDR: begin
          mem_req_s  = 1'b1;
          mem_addr_s = ADDR_PC;
          if (bus.memReady) begin
            save_addr_s = 1'b1;
            en_pc_s     = 1'b1;
            alu_a_s     = SEL_A_PC;
            alu_b_s     = SEL_B_ONE;
            alu_func_s  = FUNC_ADD;
          end else begin
            save_addr_s = 1'b0;
          end
        end
        ST_RDIR: begin
          mem_req_s  = 1'b1;
          mem_addr_s = ADDR_AREG;
          if (bus.memReady) begin
            save_mem_s = 1'b1;
          end else begin
            save_mem_s = 1'b0;
          end
        end
`endif
        ST_EXEC: begin
          alu_a_s = s1_s[2] ? SEL_A_MEM : reg_sel(s1_s[1:0]);
          if (cls_s == CL_A) begin
            alu_b_s    = reg_sel(bus.opcode[4:3]);
            alu_func_s = bus.opcode[8:5];
            if (!exec_fault_s) begin
              reg_write_s = reg_onehot(bus.opcode[1:0]);
            end else begin
              reg_write_s = '0;
            end
          end else if (cls_s == CL_I) begin
            alu_b_s    = SEL_B_IMM;
            alu_func_s = {bus.opcode[8], bus.opcode[8], bus.opcode[13:12]};
            if (!exec_fault_s && !s1_s[2]) begin
              reg_write_s = reg_onehot(s1_s[1:0]);
            end else begin
              reg_write_s = '0;
            end
          end else begin
            reg_write_s = '0;
          end
        end
        ST_HALT: begin
          halted_s = 1'b1;
        end
        default: begin
          halted_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.memReq     = mem_req_s;
  assign bus.memAddr    = mem_addr_s;
  assign bus.enPC       = en_pc_s;
  assign bus.saveOpcode = save_opcode_s;
  assign bus.saveMem    = save_mem_s;
  assign bus.saveAddr   = save_addr_s;
  assign bus.aluFunc    = alu_func_s;
  assign bus.aluA       = alu_a_s;
  assign bus.aluB       = alu_b_s;
  assign bus.regWrite   = reg_write_s;
  assign bus.halted     = halted_s;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the RCPU datapath. It is the successor to the fixed 4-register controller. It adds:
- a one-cycle DECODE state, so decisions use the registered opcode;
- a memory ready/request handshake with wait states;
- a parametrised register file size;
- an explicit halt instruction and a `halted` status flag;
- an optional direct (memory-address) operand mode.

It sits between the instruction register and the datapath muxes and register write enables.

## Interface
Parameters:
- `REGS`, default 4: number of general registers. Must be 2 or 4. Register select codes are `0..REGS-1`.
- `AW`, default 3: width of the `aluA`/`aluB` select buses.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `opcode`  in  16  contents of the instruction register.
- `memReady`  in  1  memory completes the current request this cycle.
- `memReq`  out  1  memory access requested.
- `memAddr`  out  2  memory address source: 0 = PC, 1 = address register.
- `enPC`  out  1  write the ALU result to PC.
- `saveOpcode`  out  1  load the instruction register from memory.
- `saveMem`  out  1  load the value register from memory.
- `saveAddr`  out  1  load the address register from memory.
- `aluFunc`  out  4  ALU function.
- `aluA`  out  AW  ALU input A select: `0..REGS-1` = register, 4 = MEM, 5 = PC.
- `aluB`  out  AW  ALU input B select: `0..REGS-1` = register, 4 = constant 1, 5 = opcode immediate.
- `regWrite`  out  REGS  one-hot register write enable.
- `halted`  out  1  the FSM is in HALT.

## Operation
Opcode fields:
- `s1 = opcode[11:9]`.
- Instruction class:
  - A-type: `opcode[15:12]=0000`.
  - HLT: `opcode[15:12]=0001`.
  - I-type: `opcode[15:14]=01`.
  - Any other value is invalid.

States and transitions:
- **FETCH**
  - Outputs: `memReq=1`, `memAddr=0`.
  - When `memReady`: `saveOpcode=1`, PC increment (`aluA=5`, `aluB=4`, `aluFunc=0`, `enPC=1`), then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**
  - All outputs 0.
  - Invalid opcode or HLT -> HALT.
  - A-type or I-type:
    - `s1[2]=0` -> EXEC.
    - `s1=100` -> RIMM.
    - `s1=101` -> RADDR (only when direct mode is compiled in).
    - Otherwise -> HALT.
- **RIMM**
  - Outputs: `memReq=1`, `memAddr=0`.
  - On `memReady`: `saveMem=1`, PC increment, then go to EXEC.
- **RADDR**
  - Outputs: `memReq=1`, `memAddr=0`.
  - On `memReady`: `saveAddr=1`, PC increment, then go to RDIR.
- **RDIR**
  - Outputs: `memReq=1`, `memAddr=1`.
  - On `memReady`: `saveMem=1`, then go to EXEC.
- **EXEC**
  - ALU input A: `aluA = s1[2] ? 4 : s1[1:0]`.
  - A-type:
    - `aluB = opcode[4:3]`, `aluFunc = opcode[8:5]`.
    - Destination is `opcode[1:0]`; assert `regWrite[dest]` only if `dest < REGS`.
  - I-type:
    - `aluB = 5`, `aluFunc = {opcode[8], opcode[8], opcode[13:12]}`.
    - Destination is `s1[1:0]`; assert `regWrite[dest]` only if `s1[2]=0` and `s1[1:0] < REGS`.
  - Register-source operand codes `>= REGS` -> HALT, with no write.
  - Next state: FETCH.
- **HALT**
  - `halted=1`; all other outputs 0.
  - Terminal; only reset leaves HALT.

Output rules:
- Outputs are combinational from the state, `opcode` and `memReady`.
- While `memReady=0`, only `memReq` and `memAddr` are asserted; every write enable stays 0.

## Timing
Reset:
- `rst` high forces the state to FETCH asynchronously and forces every output to 0 combinationally, including `memReq` and `halted`.
- The first cycle after release is FETCH with `memReq=1`.
- Reset mid-instruction abandons the instruction with no partial writes after assertion.

Latency with zero-wait memory, in cycles from FETCH entry to the cycle `regWrite` is asserted:
- register source: 3 (FETCH, DECODE, EXEC);
- immediate: 4;
- direct: 5.

Wait states:
- Each cycle of `memReady=0` in a memory state adds one cycle.
- `memReady` is ignored in DECODE, EXEC and HALT.

Handshake:
- `memReq` remains high, with a stable `memAddr`, until the cycle `memReady=1`.
- That cycle is the single cycle of the write enables.

## Configuration
Macro `CPU_SEQ_DIRECT_EN`:
- Defined: RADDR and RDIR exist, and `s1=101` is direct mode.
- Undefined: those states are not built, and `s1=101` in DECODE -> HALT.

## Test plan
- Reset mid-RIMM:
  - `rst` pulse -> all outputs 0 during reset.
  - Next cycle is FETCH with `memReq=1`, `memAddr=0`.
- A-type `0x0049` (`s1=000`, `aluFunc=0010`, `aluB=01`, dest=01), `memReady` tied 1:
  - EXEC on cycle 3 shows `aluA=0`, `aluB=1`, `aluFunc=2`, `regWrite=0010`.
- I-type `0x5820` (`s1=100`, immediate source):
  - FETCH, DECODE, RIMM (`saveMem=1`, `enPC=1`), EXEC with `aluA=4`, `aluB=5`, `regWrite=0000`.
- `memReady` low for 3 cycles in FETCH:
  - `memReq=1` and `saveOpcode=0` for 3 cycles, then `saveOpcode=1` and `enPC=1` in exactly one cycle.
- Opcode `0x1000` (HLT) and opcode `0xC000` (invalid):
  - Each reaches HALT after DECODE with `halted=1`.
  - The FSM stays there for 20 cycles regardless of `memReady`.
- `s1=101` (opcode `0x0A00`):
  - With the macro: RADDR, then RDIR with `memAddr=1`, then EXEC.
  - Without the macro: HALT after DECODE.
